// File: rtl/cdb_pkg.sv
// Common data bus arbiter shared definitions.
// Default requester count, grant-index width helper, payload types.
package cdb_pkg;

  localparam int N_REQ_DEF = 4;

  function automatic int gid_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int GID_W = gid_w(N_REQ_DEF);

  typedef logic [7:0] payload_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_picker
  import cdb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = gid_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [W-1:0]     winner,
  output logic             any_valid
);

  int idx;

  // Scan offsets high to low so the lowest offset from ptr wins last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        winner    = W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant of N_REQ
// requesters into a single registered output slot.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int  N_REQ = N_REQ_DEF,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  T                         req_data [N_REQ],
  output logic                     valid_out,
  input  logic                     ready_out,
  output T                         data_out,
  output logic [gid_w(N_REQ)-1:0]  grant_id
);

  localparam int W = gid_w(N_REQ);

  logic [W-1:0] ptr;
  logic [W-1:0] winner;
  logic [W-1:0] ptr_nxt;
  logic         any_valid;
  logic         load_en;
  logic         hs;

  rr_picker #(
    .N_REQ (N_REQ),
    .W     (W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign load_en = !valid_out || ready_out;
  assign hs      = !reset && any_valid && load_en;

  assign ptr_nxt = (winner == W'(N_REQ - 1))
                 ? '0 : winner + 1'b1;

  // One-hot accept toward the winner whenever the slot can load.
  always_comb begin
    req_ready = '0;
    if (hs) req_ready[winner] = 1'b1;
  end

  // Output slot: load on handshake, drain on consumer accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      ptr       <= '0;
      grant_id  <= '0;
      data_out  <= '0;
    end else if (hs) begin
      valid_out <= 1'b1;
      data_out  <= req_data[winner];
      grant_id  <= winner;
      ptr       <= ptr_nxt;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with a queue-based
// round-robin reference model and a payload scoreboard.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valid;
  logic [3:0] req_ready;
  logic [7:0] rd [4];
  logic       valid_out;
  logic       ready_out;
  logic [7:0] data_out;
  logic [1:0] grant_id;

  logic [2:0] v3;
  logic [2:0] rr3;
  logic [7:0] rd3 [3];
  logic       vo3;
  logic       ro3;
  logic [7:0] do3;
  logic [1:0] gid3;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(4), .T(logic [7:0])) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (valid),
    .req_ready (req_ready),
    .req_data  (rd),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .grant_id  (grant_id)
  );

  cdb_arbiter #(.N_REQ(3), .T(logic [7:0])) dut3 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (v3),
    .req_ready (rr3),
    .req_data  (rd3),
    .valid_out (vo3),
    .ready_out (ro3),
    .data_out  (do3),
    .grant_id  (gid3)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int         m_ptr;
  logic       m_vo;
  logic [7:0] m_data;
  int         m_gid;
  logic [7:0] sb [$];
  int         sb_err = 0;
  int         n_hs = 0;
  int         n_xfer = 0;

  function automatic logic [3:0] exp_ready();
    if (reset || (m_vo && !ready_out)) return 4'b0;
    for (int k = 0; k < 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (valid[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) rd3[i] = 8'($urandom);
  endtask

  task automatic cycle();
    logic [3:0] r;
    int w;
    r = exp_ready();
    if (!reset && valid_out && ready_out) begin
      n_xfer++;
      if (sb.size() == 0) sb_err++;
      else if (sb.pop_front() !== data_out) sb_err++;
    end
    if (reset) begin
      m_vo = 1'b0; m_ptr = 0; m_gid = 0; m_data = '0;
      sb.delete();
    end else if (r != 4'b0) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (r[i]) w = i;
      sb.push_back(rd[w]);
      n_hs++;
      m_data = rd[w]; m_gid = w; m_vo = 1'b1;
      m_ptr = (w + 1) % 4;
    end else if (m_vo && ready_out) begin
      m_vo = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = '0; ready_out = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 4'($urandom);
    ready_out = 1'b1;
    rand_data();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    cycle();
    cycle();
    n_cmp++;
    if (valid_out !== 1'b0 || grant_id !== 2'd0 || data_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b g=%0d d=%h want 0/0/00",
               valid_out, grant_id, data_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    valid = 4'b1111; ready_out = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << seq[c])) begin
        n_fail++;
        $display("FAIL rr_ready c%0d got %b want %b",
                 c, req_ready, 4'(1 << seq[c]));
      end
      cycle();
      n_cmp++;
      if (valid_out !== 1'b1 || grant_id !== 2'(seq[c])
          || data_out !== m_data) begin
        n_fail++;
        $display("FAIL rr_grant c%0d got v=%b g=%0d d=%h want 1/%0d/%h",
                 c, valid_out, grant_id, data_out, seq[c], m_data);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rand_data();
    valid = 4'b0010; ready_out = 1'b1;
    cycle();
    valid = 4'b0011;
    rand_data();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_ready got %b want 0001", req_ready);
    end
    cycle();
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_grant got %0d want 0", grant_id);
    end
    rand_data();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_ready2 got %b want 0010", req_ready);
    end
    cycle();
    n_cmp++;
    if (grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_grant2 got %0d want 1", grant_id);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    logic [7:0] nw;
    do_reset();
    rand_data();
    valid = 4'b0100; ready_out = 1'b1;
    cycle();
    held = m_data;
    ready_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      #1;
      n_cmp++;
      if (req_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL bp_ready c%0d got %b want 0000", c, req_ready);
      end
      cycle();
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== held
          || grant_id !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold c%0d got v=%b d=%h g=%0d want 1/%h/2",
                 c, valid_out, data_out, grant_id, held);
      end
    end
    ready_out = 1'b1;
    rand_data();
    nw = rd[2];
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release got %b want 0100", req_ready);
    end
    cycle();
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== nw) begin
      n_fail++;
      $display("FAIL bp_nobubble got v=%b d=%h want 1/%h",
               valid_out, data_out, nw);
    end
  endtask

  task automatic test_drain();
    int hs0;
    int x0;
    do_reset();
    hs0 = n_hs; x0 = n_xfer;
    rand_data();
    valid = 4'b0001; ready_out = 1'b1;
    cycle();
    valid = 4'b0000;
    cycle();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_valid got %b want 0", valid_out);
    end
    cycle();
    n_cmp++;
    if (n_xfer - x0 != 1 || n_hs - hs0 != 1) begin
      n_fail++;
      $display("FAIL drain_count got xfer=%0d hs=%0d want 1/1",
               n_xfer - x0, n_hs - hs0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_data();
    valid = 4'b1000; ready_out = 1'b1;
    cycle();
    valid = 4'b0000; ready_out = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_valid got %b want 0", valid_out);
    end
    reset = 1'b0; ready_out = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_ghost got %b want 0", valid_out);
    end
    valid = 4'b1111;
    rand_data();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmid_ptr got %b want 0001", req_ready);
    end
    cycle();
    valid = 4'b0000;
    cycle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      valid = 4'($urandom);
      ready_out = ($urandom_range(0, 3) != 0);
      rand_data();
      #1;
      n_cmp++;
      if (req_ready !== exp_ready()) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_ready c%0d got %b want %b",
                   c, req_ready, exp_ready());
      end
      cycle();
      n_cmp++;
      if (valid_out !== m_vo
          || (m_vo && (grant_id !== 2'(m_gid) || data_out !== m_data))) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_out c%0d got v=%b g=%0d d=%h want %b/%0d/%h",
                   c, valid_out, grant_id, data_out, m_vo, m_gid, m_data);
      end
    end
    reset = 1'b0;
    valid = '0;
    ready_out = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (sb_err != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard got err=%0d left=%0d want 0/0",
               sb_err, sb.size());
    end
  endtask

  task automatic test_n3();
    int seq [4] = '{0, 1, 2, 0};
    reset = 1'b1; v3 = '0; ro3 = 1'b0;
    valid = '0; ready_out = 1'b1;
    cycle();
    reset = 1'b0;
    v3 = 3'b111; ro3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rand_data();
      cycle();
      n_cmp++;
      if (vo3 !== 1'b1 || gid3 !== 2'(seq[c])) begin
        n_fail++;
        $display("FAIL n3_grant c%0d got v=%b g=%0d want 1/%0d",
                 c, vo3, gid3, seq[c]);
      end
    end
    v3 = '0;
  endtask

  initial begin
    reset = 1'b1; valid = '0; ready_out = 1'b0;
    v3 = '0; ro3 = 1'b1;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    for (int i = 0; i < 3; i++) rd3[i] = '0;
    m_ptr = 0; m_vo = 1'b0; m_data = '0; m_gid = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    test_n3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
